// File: rtl/pipeline_control_arbiter.sv
// Resolves per-source pipeline control requests into one control word, with
// exclusive locking, barrier stall/reset conflict cleanup and a stall watchdog.

package pipeline_control_arbiter_pkg;

  typedef struct packed {
    logic active;
    logic exclusive;
    logic IF_ID_stall;
    logic ID_EX_stall;
    logic EX_MEM_stall;
    logic MEM_WB_stall;
    logic IF_ID_reset;
    logic ID_EX_reset;
    logic EX_MEM_reset;
    logic MEM_WB_reset;
    logic force_sr1_load;
    logic force_sr2_load;
    logic fetch_stall;
    logic decode_stall;
    logic execute_stall;
    logic mem_stall;
  } lc3b_pipeline_control_word;

endpackage

module pipeline_control_arbiter
  import pipeline_control_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WATCHDOG_MAX = 1023
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  lc3b_pipeline_control_word [NUM_REQ-1:0]  request,
  output lc3b_pipeline_control_word                pipeline_control,
  output logic [NUM_REQ-1:0]                       grant,
  output logic                                     locked,
  output logic [$clog2(NUM_REQ)-1:0]               lock_owner,
  output logic [15:0]                              stall_cycles,
  output logic                                     watchdog_timeout
);

  localparam int          IW      = $clog2(NUM_REQ);
  localparam logic [15:0] WdLimit = 16'(WATCHDOG_MAX);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d;
  logic [15:0]               stall_q, stall_d;
  logic                      wd_q, wd_d;

  lc3b_pipeline_control_word merged;
  logic [NUM_REQ-1:0]        mergeGrant;
  logic                      exclFound;
  logic [IW-1:0]             exclIdx;
  lc3b_pipeline_control_word word;
  logic [NUM_REQ-1:0]        wordGrant;

  // Shared OR-merge of every active source, and the lowest-index exclusive requester.
  always_comb begin
    merged     = '0;
    mergeGrant = '0;
    exclFound  = 1'b0;
    exclIdx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (request[i].active) begin
        merged        = lc3b_pipeline_control_word'(merged | request[i]);
        mergeGrant[i] = 1'b1;
      end
    end
    merged.active    = |mergeGrant;
    merged.exclusive = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (request[i].active && request[i].exclusive) begin
        exclFound = 1'b1;
        exclIdx   = i[IW-1:0];
      end
    end
  end

  // A release cycle is always resolved by the merge, so relock needs a fresh IDLE cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    word      = merged;
    wordGrant = mergeGrant;
    unique case (state_q)
      IDLE: begin
        if (exclFound) begin
          word               = request[exclIdx];
          word.exclusive     = 1'b1;
          wordGrant          = '0;
          wordGrant[exclIdx] = 1'b1;
          state_d            = LOCKED;
          owner_d            = exclIdx;
        end
      end
      LOCKED: begin
        if (request[owner_q].active) begin
          word               = request[owner_q];
          word.exclusive     = 1'b1;
          wordGrant          = '0;
          wordGrant[owner_q] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    word.IF_ID_stall  = word.IF_ID_stall  & ~word.IF_ID_reset;
    word.ID_EX_stall  = word.ID_EX_stall  & ~word.ID_EX_reset;
    word.EX_MEM_stall = word.EX_MEM_stall & ~word.EX_MEM_reset;
    word.MEM_WB_stall = word.MEM_WB_stall & ~word.MEM_WB_reset;

    if (reset) begin
      word      = '0;
      wordGrant = '0;
    end
  end

  // Stall duration counter and sticky watchdog flag.
  always_comb begin
    if (!word.active) begin
      stall_d = 16'd0;
    end else if (stall_q == 16'hFFFF) begin
      stall_d = stall_q;
    end else begin
      stall_d = stall_q + 16'd1;
    end
    wd_d = wd_q | ((stall_d == WdLimit) && (stall_q != WdLimit));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      stall_q <= 16'd0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      stall_q <= stall_d;
      wd_q    <= wd_d;
    end
  end

  assign pipeline_control = word;
  assign grant            = wordGrant;
  assign locked           = (state_q == LOCKED);
  assign lock_owner       = owner_q;
  assign stall_cycles     = stall_q;
  assign watchdog_timeout = wd_q;

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// Directed and random checks of pipeline_control_arbiter against a
// cycle-level priority/lock reference model.

module tb_pipeline_control_arbiter;
  import pipeline_control_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int WD = 8;

  typedef lc3b_pipeline_control_word word_t;

  logic              clk = 1'b0;
  logic              reset;
  word_t [NR-1:0]    request;
  word_t             pipeline_control;
  logic [NR-1:0]     grant;
  logic              locked;
  logic [1:0]        lock_owner;
  logic [15:0]       stall_cycles;
  logic              watchdog_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 when unlocked), stall count, sticky flag.
  int          mOwner;
  int          nOwner;
  int unsigned mStall;
  bit          mWd;
  word_t       eCtl;
  logic [3:0]  eGrant;

  word_t       lastCtl;
  logic [3:0]  lastGrant;

  pipeline_control_arbiter #(
    .NUM_REQ      (NR),
    .WATCHDOG_MAX (WD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .request          (request),
    .pipeline_control (pipeline_control),
    .grant            (grant),
    .locked           (locked),
    .lock_owner       (lock_owner),
    .stall_cycles     (stall_cycles),
    .watchdog_timeout (watchdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelComb(input word_t [NR-1:0] r);
    int ex;
    logic [3:0] st, rs;
    eCtl   = '0;
    eGrant = '0;
    nOwner = -1;
    ex     = -1;
    if (mOwner >= 0 && r[mOwner].active) begin
      eCtl           = r[mOwner];
      eCtl.exclusive = 1'b1;
      eGrant         = 4'(1 << mOwner);
      nOwner         = mOwner;
    end else begin
      if (mOwner < 0)
        for (int i = 0; i < NR; i++)
          if (ex < 0 && r[i].active && r[i].exclusive) ex = i;
      if (ex >= 0) begin
        eCtl           = r[ex];
        eCtl.exclusive = 1'b1;
        eGrant         = 4'(1 << ex);
        nOwner         = ex;
      end else begin
        for (int i = 0; i < NR; i++)
          if (r[i].active) begin
            eCtl      = word_t'(eCtl | r[i]);
            eGrant[i] = 1'b1;
          end
        eCtl.active    = (eGrant != 0);
        eCtl.exclusive = 1'b0;
      end
    end
    st = {eCtl.IF_ID_stall, eCtl.ID_EX_stall, eCtl.EX_MEM_stall, eCtl.MEM_WB_stall};
    rs = {eCtl.IF_ID_reset, eCtl.ID_EX_reset, eCtl.EX_MEM_reset, eCtl.MEM_WB_reset};
    st = st & ~rs;
    {eCtl.IF_ID_stall, eCtl.ID_EX_stall, eCtl.EX_MEM_stall, eCtl.MEM_WB_stall} = st;
  endtask

  task automatic modelSeq();
    int unsigned prev;
    prev   = mStall;
    mStall = eCtl.active ? ((mStall == 65535) ? 65535 : mStall + 1) : 0;
    if (mStall == WD && prev != WD) mWd = 1'b1;
    mOwner = nOwner;
  endtask

  task automatic modelReset();
    mOwner = -1;
    mStall = 0;
    mWd    = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // then registered outputs just after the rising edge.
  task automatic applyStimulus(input word_t [NR-1:0] r);
    request = r;
    #1;
    modelComb(r);
    lastCtl   = pipeline_control;
    lastGrant = grant;
    checkOutput("ctl", pipeline_control, eCtl);
    checkOutput("grant", grant, eGrant);
    @(posedge clk);
    modelSeq();
    #1;
    checkOutput("locked", locked, mOwner >= 0);
    if (mOwner >= 0) checkOutput("owner", lock_owner, mOwner);
    checkOutput("stall", stall_cycles, mStall);
    checkOutput("wdog", watchdog_timeout, mWd);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctl"}, pipeline_control, 0);
    checkOutput({tag, "_grant"}, grant, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_owner"}, lock_owner, 0);
    checkOutput({tag, "_stall"}, stall_cycles, 0);
    checkOutput({tag, "_wdog"}, watchdog_timeout, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkResetOutputs("rst");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic word_t randWord();
    word_t w;
    w           = word_t'($urandom);
    w.active    = ($urandom_range(0, 2) != 0);
    w.exclusive = ($urandom_range(0, 3) == 0);
    return w;
  endfunction

  initial begin
    word_t [NR-1:0] r;
    word_t          e;

    reset   = 1'b1;
    request = '0;
    modelReset();
    doReset();

    // Merge of two non-exclusive sources.
    r = '0;
    r[0].active = 1'b1; r[0].ID_EX_stall = 1'b1;
    r[2].active = 1'b1; r[2].EX_MEM_reset = 1'b1;
    applyStimulus(r);
    e = '0; e.active = 1'b1; e.ID_EX_stall = 1'b1; e.EX_MEM_reset = 1'b1;
    checkOutput("merge_ctl", lastCtl, e);
    checkOutput("merge_grant", lastGrant, 4'b0101);
    checkOutput("merge_locked", locked, 0);

    // Priority lock: src1 beats src3.
    r = '0;
    r[1].active = 1'b1; r[1].exclusive = 1'b1; r[1].MEM_WB_stall = 1'b1; r[1].fetch_stall = 1'b1;
    r[3].active = 1'b1; r[3].exclusive = 1'b1; r[3].force_sr1_load = 1'b1;
    applyStimulus(r);
    checkOutput("lock_ctl", lastCtl, r[1]);
    checkOutput("lock_grant", lastGrant, 4'b0010);
    checkOutput("lock_locked", locked, 1);
    checkOutput("lock_owner", lock_owner, 1);

    // Hold: src0 masked while src1 owns, src3 cannot steal.
    r[0].active = 1'b1; r[0].IF_ID_stall = 1'b1;
    applyStimulus(r);
    checkOutput("hold_ctl", lastCtl, r[1]);
    checkOutput("hold_grant", lastGrant, 4'b0010);

    // Release: same cycle resolved by merge of src0 only.
    r[1] = '0;
    r[3] = '0;
    applyStimulus(r);
    checkOutput("rel_ctl", lastCtl, r[0]);
    checkOutput("rel_grant", lastGrant, 4'b0001);
    checkOutput("rel_locked", locked, 0);

    // Barrier conflict: reset wins over stall, stage stalls untouched.
    r = '0;
    r[0].active = 1'b1; r[0].ID_EX_stall = 1'b1; r[0].ID_EX_reset = 1'b1; r[0].decode_stall = 1'b1;
    r[1].active = 1'b1; r[1].execute_stall = 1'b1;
    applyStimulus(r);
    e = '0; e.active = 1'b1; e.ID_EX_reset = 1'b1; e.decode_stall = 1'b1; e.execute_stall = 1'b1;
    checkOutput("conf_ctl", lastCtl, e);

    // Watchdog reaches its limit and stays sticky once activity stops.
    doReset();
    r = '0;
    r[2].active = 1'b1; r[2].decode_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(r);
      if (i == 6) checkOutput("wd_before", watchdog_timeout, 0);
      if (i == 7) begin
        checkOutput("wd_count", stall_cycles, 8);
        checkOutput("wd_set", watchdog_timeout, 1);
      end
    end
    applyStimulus('0);
    checkOutput("wd_idle_stall", stall_cycles, 0);
    checkOutput("wd_sticky", watchdog_timeout, 1);

    // Asynchronous reset while locked, with X requests during reset.
    doReset();
    r = '0;
    r[3].active = 1'b1; r[3].exclusive = 1'b1; r[3].mem_stall = 1'b1;
    applyStimulus(r);
    checkOutput("pre_async_locked", locked, 1);
    reset = 1'b1;
    #1;
    checkResetOutputs("async");
    modelReset();
    request = 'x;
    #1;
    checkOutput("x_ctl", pipeline_control, 0);
    checkOutput("x_grant", grant, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(r);
    checkOutput("resume_grant", lastGrant, 4'b1000);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) r[i] = randWord();
      if ($urandom_range(0, 7) == 0) r = '0;
      applyStimulus(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_arbiter.md
Name: pipeline_control_arbiter

Overview:
- Receiving end of the pipeline control request interface.
- Collects one lc3b_pipeline_control_word request from each hazard source: forwarding controller, branch controller, I-cache miss, D-cache miss.
- Resolves those requests into the single control word that drives the barrier stall/reset/force-load lines and the stage stalls.
- Tracks exclusive ownership across cycles and monitors stall duration.

Parameters:
- NUM_REQ, 4, number of requester slots; index 0 has the highest priority.
- WATCHDOG_MAX, 1023, consecutive active cycles after which watchdog_timeout sets.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- request  input  NUM_REQ x lc3b_pipeline_control_word  per-source requests.
- pipeline_control  output  lc3b_pipeline_control_word  resolved control to barriers and stages.
- grant  output  NUM_REQ  one bit per source whose request contributed this cycle.
- locked  output  1  arbiter is in the LOCKED state.
- lock_owner  output  $clog2(NUM_REQ)  index of the exclusive owner; valid when locked=1.
- stall_cycles  output  16  consecutive cycles with pipeline_control.active=1; saturates.
- watchdog_timeout  output  1  sticky; set when stall_cycles reaches WATCHDOG_MAX.

Behaviour:
- Clocking and outputs: one clock; reset is asynchronous and active-high. pipeline_control and grant are combinational from request and state. locked, lock_owner, stall_cycles and watchdog_timeout are registered.
- While reset is high:
  - pipeline_control is all-zero and grant=0, regardless of request.
  - State is IDLE, lock_owner=0, stall_cycles=0, watchdog_timeout=0.
- Shared merge rule (used in IDLE with no exclusive request, and on LOCKED release):
  - Every source with active=1 contributes and sets its grant bit.
  - All stall, reset, force_sr1_load and force_sr2_load fields are bitwise-ORed across contributors.
  - Output active = 1 if any source contributed. Output exclusive = 0.
- Barrier conflict rule, applied to the final output in every state:
  - For each barrier, if its reset is 1, its stall is forced to 0.
  - Stage stalls are not affected.
- IDLE state:
  - If any source has active=1 and exclusive=1:
    - The lowest-index such source is the sole contributor; the output is its word verbatim, except that exclusive=1 and the conflict rule applies.
    - grant is one-hot on that source.
    - Next state is LOCKED and lock_owner is set to that index.
  - Otherwise the shared merge rule applies and the state stays IDLE.
- LOCKED state:
  - If request[lock_owner].active=1:
    - The output is the owner's word only, even if the owner has dropped its exclusive bit. Output exclusive = 1.
    - grant is one-hot on the owner. All other sources are masked.
  - If request[lock_owner].active=0:
    - The same cycle is resolved with the shared merge rule; exclusive requests are not honoured that cycle.
    - Next state is IDLE. Relock can occur one cycle later at the earliest.
  - Ownership cannot be taken by a higher-priority source while locked.
- stall_cycles:
  - Increments on each clock edge where output active=1.
  - Clears to 0 on any edge where output active=0.
  - Saturates at 16'hFFFF.
- watchdog_timeout:
  - Sets on the edge where stall_cycles transitions to WATCHDOG_MAX.
  - Stays set until reset.
  - Has no effect on pipeline_control.
- Simultaneous events:
  - Owner release and a new exclusive request in the same cycle: release wins; the lock goes to the new source on the following cycle if it is still requesting.
  - Reset asserted mid-lock: returns to IDLE immediately (asynchronous) and clears all outputs.
- Unknown or X request fields while reset=1 must not propagate to the outputs.

Test Plan:
- Merge: src0 = {active, ID_EX_stall}, src2 = {active, EX_MEM_reset}, no exclusive -> active=1, ID_EX_stall=1, EX_MEM_reset=1, exclusive=0, grant=4'b0101, locked stays 0.
- Priority lock: src1 and src3 both active+exclusive at cycle 0 -> cycle 0 output = src1 word with exclusive=1, grant=4'b0010; cycle 1 shows locked=1, lock_owner=1.
- Lock hold and release: while locked to src1, src0 asserts non-exclusive IF_ID_stall -> masked, grant=4'b0010. src1 drops active -> same cycle output = src0 word, grant=4'b0001; next cycle locked=0.
- Conflict: merged request has ID_EX_stall=1 and ID_EX_reset=1 -> output ID_EX_stall=0, ID_EX_reset=1; stage stalls unchanged.
- Watchdog: WATCHDOG_MAX=8, src2 active for 10 cycles -> stall_cycles reaches 8 and watchdog_timeout=1 on that edge; src2 idle -> stall_cycles=0 and watchdog_timeout stays 1.
- Async reset mid-lock: assert reset between clock edges while locked=1 -> outputs zero with no clock edge, locked=0, lock_owner=0, stall_cycles=0, watchdog_timeout=0; after deassert, behaviour resumes from IDLE.
